// File: rtl/decode_issue_queue.sv
// Instruction buffer between fetch and the alpha/beta decode lanes: stores up to
// FETCH_W instructions per cycle with a registered pre-decode and selects one or two to issue.
module decode_issue_queue #(
    parameter int DEPTH      = 16,
    parameter int FETCH_W    = 2,
    parameter int DUAL_ISSUE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [$clog2(FETCH_W+1)-1:0] in_count,
    input  logic [32*FETCH_W-1:0]        in_instr,
    input  logic [32*FETCH_W-1:0]        in_pc,
    output logic                         in_ready,
    input  logic                         issue_ready,
    output logic                         alpha_valid,
    output logic [31:0]                  alpha_instr,
    output logic [31:0]                  alpha_pc,
    output logic [4:0]                   alpha_wb_dest,
    output logic                         alpha_wb_en,
    output logic                         beta_valid,
    output logic [31:0]                  beta_instr,
    output logic [31:0]                  beta_pc,
    output logic [4:0]                   beta_wb_dest,
    output logic                         beta_wb_en,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH+1);
    localparam bit DUAL = (DUAL_ISSUE != 0);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  wb_dest;
        logic        wb_en;
        logic        is_branch;
        logic        is_mem;
        logic        is_priv;
        logic        is_hilo;
        logic        rs_used;
        logic        rt_used;
    } entry_t;

    function automatic entry_t predecode(input logic [31:0] instr, input logic [31:0] pc);
        entry_t     e;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       r_type, r_alu, r_shift, r_mf, r_jalr, r_trap;
        op      = instr[31:26];
        fn      = instr[5:0];
        rs      = instr[25:21];
        rt      = instr[20:16];
        rd      = instr[15:11];
        r_type  = (op == 6'b000000);
        r_alu   = r_type && (fn[5:4] == 2'b10);
        r_shift = r_type && (fn[5:3] == 3'b000);
        r_mf    = r_type && ((fn == 6'b010000) || (fn == 6'b010010));
        r_jalr  = r_type && (fn == 6'b001001);
        r_trap  = r_type && ((fn == 6'b001100) || (fn == 6'b001101));
        e           = '0;
        e.instr     = instr;
        e.pc        = pc;
        e.is_branch = (op == 6'b000010) || (op == 6'b000011) || (op[5:2] == 4'b0001) ||
                      (op == 6'b000001) || (r_type && ((fn == 6'b001000) || r_jalr));
        e.is_mem    = op[5];
        e.is_priv   = (op == 6'b010000) || r_trap;
        e.is_hilo   = r_type && ((fn[5:2] == 4'b0110) || (fn[5:2] == 4'b0100));
        if (r_alu || r_shift || r_mf || r_jalr) begin
            e.wb_dest = rd;
            e.wb_en   = 1'b1;
        end else if ((op[5:3] == 3'b001) || (op[5:3] == 3'b100) ||
                     ((op == 6'b010000) && (rs == 5'b00000))) begin
            e.wb_dest = rt;
            e.wb_en   = 1'b1;
        end else if ((op == 6'b000011) ||
                     ((op == 6'b000001) && ((rt == 5'b10000) || (rt == 5'b10001)))) begin
            e.wb_dest = 5'd31;
            e.wb_en   = 1'b1;
        end
        // Immediate shifts, MFHI/MFLO and traps read no rs; LUI reads nothing.
        if (r_type)
            e.rs_used = !((r_shift && !fn[2]) || r_mf || r_trap);
        else
            e.rs_used = (op[5:2] == 4'b0001) || (op == 6'b000001) || op[5] ||
                        ((op[5:3] == 3'b001) && (op != 6'b001111));
        if (r_type)
            e.rt_used = r_alu || r_shift || (fn[5:2] == 4'b0110);
        else
            e.rt_used = (op[5:1] == 5'b00010) || (op[5:3] == 3'b101) ||
                        ((op == 6'b010000) && (rs == 5'b00100));
        return e;
    endfunction

    entry_t        mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;
    entry_t        a_ent, b_ent;
    logic          alpha_v, beta_v, raw, slot_bad, push;
    logic [CW-1:0] pushed, popped;

    // Handshake: fetch data is taken on any edge where in_ready && in_count>0; issued
    // instructions are consumed on any edge where issue_ready is high, for each valid lane.
    assign in_ready = (cnt <= CW'(DEPTH - FETCH_W));
    assign push     = in_ready && (in_count != '0);
    assign a_ent    = mem[head];
    assign b_ent    = mem[head + PW'(1)];

    always_comb begin
        raw      = a_ent.wb_en && (a_ent.wb_dest != 5'd0) &&
                   ((b_ent.rs_used && (a_ent.wb_dest == b_ent.instr[25:21])) ||
                    (b_ent.rt_used && (a_ent.wb_dest == b_ent.instr[20:16])));
        slot_bad = b_ent.is_branch || b_ent.is_priv;
        alpha_v  = 1'b0;
        beta_v   = 1'b0;
        if (cnt != '0) begin
            if (a_ent.is_branch) begin
                // A branch only leaves together with a legal delay slot.
                alpha_v = (cnt >= CW'(2)) && !slot_bad;
                beta_v  = DUAL && (cnt >= CW'(2)) && !slot_bad;
            end else begin
                alpha_v = 1'b1;
                beta_v  = DUAL && (cnt >= CW'(2)) && !slot_bad && !b_ent.is_mem &&
                          !a_ent.is_priv && !(a_ent.is_hilo && b_ent.is_hilo) && !raw;
            end
        end
    end

    assign pushed = push ? CW'(in_count) : '0;
    assign popped = issue_ready ? (CW'(alpha_v) + CW'(beta_v)) : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + PW'(popped);
            tail <= tail + PW'(pushed);
            cnt  <= cnt + pushed - popped;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (push && (i < int'(in_count)))
                mem[tail + PW'(i)] <= predecode(in_instr[32*i +: 32], in_pc[32*i +: 32]);
        end
    end

    assign count         = cnt;
    assign alpha_valid   = alpha_v;
    assign alpha_instr   = alpha_v ? a_ent.instr   : '0;
    assign alpha_pc      = alpha_v ? a_ent.pc      : '0;
    assign alpha_wb_dest = alpha_v ? a_ent.wb_dest : '0;
    assign alpha_wb_en   = alpha_v && a_ent.wb_en;
    assign beta_valid    = beta_v;
    assign beta_instr    = beta_v ? b_ent.instr   : '0;
    assign beta_pc       = beta_v ? b_ent.pc      : '0;
    assign beta_wb_dest  = beta_v ? b_ent.wb_dest : '0;
    assign beta_wb_en    = beta_v && b_ent.wb_en;
endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Parametrised instruction buffer and dual-issue selector between fetch and the alpha/beta decode lanes.
- Accepts up to FETCH_W instructions per cycle and stores them with a registered pre-decode.
- Each cycle it presents one or two instructions to the alpha and beta lanes, applying the pairing rules and the branch/delay-slot rules.

Parameters:
DEPTH, 16, queue entries; power of two, at least 2*FETCH_W
FETCH_W, 2, max instructions pushed per cycle (1..4)
DUAL_ISSUE, 1, 1 allows beta issue; 0 gives single-issue mode (beta_valid tied 0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  exception/mispredict flush; empties the queue
in_count  in  $clog2(FETCH_W+1)  number of valid instructions in in_instr/in_pc, slot 0 first
in_instr  in  32*FETCH_W  packed instructions, slot i at [32i+31:32i]
in_pc  in  32*FETCH_W  packed PCs
in_ready  out  1  free entries >= FETCH_W
issue_ready  in  1  backend accepts this cycle's issue
alpha_valid  out  1  head entry presented
alpha_instr  out  32  head entry instruction
alpha_pc  out  32  head entry PC
alpha_wb_dest  out  5  head entry pre-decoded destination
alpha_wb_en  out  1  head entry pre-decoded write enable
beta_valid  out  1  head+1 entry presented
beta_instr  out  32  head+1 entry instruction
beta_pc  out  32  head+1 entry PC
beta_wb_dest  out  5  head+1 entry pre-decoded destination
beta_wb_en  out  1  head+1 entry pre-decoded write enable
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage is a circular buffer with head/tail pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. Occupancy is kept in the count register.
- Push: when in_ready && in_count>0, write in_count entries at tail..tail+in_count-1 (wrapping) and advance tail by in_count. in_count > FETCH_W is illegal; the bench asserts it never occurs. When in_ready=0 the input is ignored and fetch must hold it.
- Pre-decode is computed at push time and stored per entry:
  - is_branch: opcode 000010/000011/0001xx/000001, or opcode 0 with funct 001000/001001.
  - is_mem: opcode[5]=1.
  - is_priv: opcode 010000, or opcode 0 with funct 001100/001101.
  - is_hilo: opcode 0 with funct 0110xx/0100xx.
  - wb_dest/wb_en:
    - rd for opcode 0 writers (ALU, shift, MFHI/MFLO, JALR).
    - rt for opcodes 001xxx, 100xxx, and MFC0.
    - 31 for JAL, BLTZAL, BGEZAL.
    - Otherwise wb_en=0.
  - rs_used/rt_used per operand.
- alpha_valid = count>=1. Exception: if the head is_branch and count<2, alpha_valid=0, so a branch never issues without its delay slot.
- beta_valid = DUAL_ISSUE && count>=2 && all of the following:
  - beta is not is_branch, is_mem or is_priv;
  - alpha is not is_priv;
  - not (alpha is_hilo && beta is_hilo);
  - no RAW: not (alpha wb_en && alpha wb_dest!=0 && ((beta rs_used && dest==rs) || (beta rt_used && dest==rt))).
- beta_valid is forced to 1 when alpha is_branch and count>=2 and the delay slot is not is_branch/is_priv. If the delay slot is is_branch or is_priv, beta_valid=0 and alpha_valid=0 (hold), and the bench flags this as an illegal program.
- Pop: when issue_ready, head advances by alpha_valid+beta_valid. Push and pop in the same cycle are both applied: count_next = count + pushed - popped.
- Flush: head=tail=count=0 next cycle. Flush overrides push and pop in the same cycle.
- Reset (mid-operation included): identical to flush. All out-of-reset outputs are 0: alpha_valid=0, beta_valid=0, count=0, all payload outputs 0, in_ready=1.
- Payload outputs are combinational reads of the head entries. They are zero when the corresponding valid is low.
- Full: in_ready=0 when DEPTH-count < FETCH_W, even if a pop occurs this cycle (no bypass).
- Empty: no bypass from input to output. Latency from push to earliest alpha_valid is 1 cycle.

Test Plan:
- Reset, then push 2 ADDU (rd=3, rd=4, independent) -> next cycle alpha_valid=1 and beta_valid=1; with issue_ready=1, count goes 2->0.
- Push ADDIU rt=5 followed by ADDU using rs=5 -> alpha_valid=1, beta_valid=0. Two issue cycles; second cycle alpha_instr=ADDU.
- Push BEQ alone, wait 3 cycles -> alpha_valid=0. Then push an ADDU delay slot -> both valid the next cycle and pop together.
- Fill to DEPTH=16 with issue_ready=0 -> in_ready drops at count=15 (FETCH_W=2). A pointer wrap after partial drain keeps PC order intact.
- Assert flush with a simultaneous push of 2 instructions and issue_ready=1 -> next cycle count=0, alpha_valid=0.
- DUAL_ISSUE=0 build, push 4 independent ALU ops -> beta_valid stays 0 and 4 issue cycles are needed; an LW in beta position with DUAL_ISSUE=1 also yields beta_valid=0.
